// File: rtl/clock_data_tx.sv
// Turns a 1 s snapshot of the BCD clock (plus alarm flag) into an ASCII line
// "HH:MM:SS[*]\r\n" streamed one byte at a time over a valid/ready interface.
module clock_data_tx #(
    parameter logic [7:0] SEP_CHAR     = 8'h3A,
    parameter bit         EOL_CR       = 1'b1,
    parameter bit         ALARM_TAG_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        time_1s,
    input  logic [23:0] clock_data,
    input  logic        alarm_en,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] snapTime_q, snapTime_d;
    logic        snapAlarm_q, snapAlarm_d;
    logic [7:0]  txData_q, txData_d;
    logic        txVld_q, txVld_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic [3:0]  lastIdx;
    logic        handshake;

    function automatic logic [7:0] digitChar(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    // Byte at position idx of the frame built from time t and alarm flag.
    function automatic logic [7:0] frameByte(input logic [3:0] idx, input logic [23:0] t,
                                             input logic alarm);
        logic       tag;
        logic [7:0] b;
        tag = ALARM_TAG_EN && alarm;
        case (idx)
            4'd0:    b = digitChar(t[23:20]);
            4'd1:    b = digitChar(t[19:16]);
            4'd2:    b = SEP_CHAR;
            4'd3:    b = digitChar(t[15:12]);
            4'd4:    b = digitChar(t[11:8]);
            4'd5:    b = SEP_CHAR;
            4'd6:    b = digitChar(t[7:4]);
            4'd7:    b = digitChar(t[3:0]);
            4'd8:    b = tag ? 8'h2A : (EOL_CR ? 8'h0D : 8'h0A);
            4'd9:    b = (tag && EOL_CR) ? 8'h0D : 8'h0A;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    assign lastIdx   = 4'd8 + ((ALARM_TAG_EN && snapAlarm_q) ? 4'd1 : 4'd0)
                            + (EOL_CR ? 4'd1 : 4'd0);
    assign handshake = txVld_q && tx_rdy;

    // A request arriving on the last-byte handshake chains straight into a new frame.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snapTime_d  = snapTime_q;
        snapAlarm_d = snapAlarm_q;
        txData_d    = txData_q;
        txVld_d     = txVld_q;
        busy_d      = busy_q;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (time_1s) begin
                    state_d     = SEND;
                    idx_d       = 4'd0;
                    snapTime_d  = clock_data;
                    snapAlarm_d = alarm_en;
                    txData_d    = frameByte(4'd0, clock_data, alarm_en);
                    txVld_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            SEND: begin
                if (handshake && idx_q == lastIdx) begin
                    if (time_1s) begin
                        idx_d       = 4'd0;
                        snapTime_d  = clock_data;
                        snapAlarm_d = alarm_en;
                        txData_d    = frameByte(4'd0, clock_data, alarm_en);
                    end else begin
                        state_d = IDLE;
                        txVld_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    if (handshake) begin
                        idx_d    = idx_q + 4'd1;
                        txData_d = frameByte(idx_q + 4'd1, snapTime_q, snapAlarm_q);
                    end
                    overrun_d = time_1s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            snapTime_q  <= 24'h0;
            snapAlarm_q <= 1'b0;
            txData_q    <= 8'h00;
            txVld_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snapTime_q  <= snapTime_d;
            snapAlarm_q <= snapAlarm_d;
            txData_q    <= txData_d;
            txVld_q     <= txVld_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_data = txData_q;
    assign tx_vld  = txVld_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_clock_data_tx.sv
// Bench for clock_data_tx: a frame-queue model checked every cycle, plus
// literal byte sequences for the directed scenarios.
module tb_clock_data_tx;

    typedef logic [7:0] byteQ_t[$];

    logic        clk = 1'b0;
    logic        rst, time_1s, alarm_en, tx_rdy;
    logic [23:0] clock_data;
    logic [7:0]  tx_data, tx_data2;
    logic        tx_vld, busy, overrun, tx_vld2, busy2, overrun2;

    int          checks = 0;
    int          failures = 0;
    bit          compareEn = 1'b0;
    byteQ_t      mq, log0, log1;
    bit          mBusy = 1'b0, mOver = 1'b0;
    bit          stallPrev = 1'b0;
    logic [7:0]  stallData;
    logic [23:0] curCd;
    logic        curAl;

    clock_data_tx dut (
        .clk(clk), .rst(rst), .time_1s(time_1s), .clock_data(clock_data),
        .alarm_en(alarm_en), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .busy(busy), .overrun(overrun)
    );

    clock_data_tx #(.SEP_CHAR(8'h3A), .EOL_CR(1'b0), .ALARM_TAG_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .time_1s(time_1s), .clock_data(clock_data),
        .alarm_en(alarm_en), .tx_data(tx_data2), .tx_vld(tx_vld2), .tx_rdy(tx_rdy),
        .busy(busy2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] asciiDigit(input logic [3:0] d);
        if (d <= 4'd9) return 8'h30 + {4'h0, d};
        return 8'h3F;
    endfunction

    function automatic byteQ_t buildFrame(input logic [23:0] t, input logic a,
                                          input bit tagEn, input bit cr);
        byteQ_t f;
        f = {};
        for (int k = 5; k >= 0; k--) begin
            f.push_back(asciiDigit(t[k*4 +: 4]));
            if (k == 4 || k == 2) f.push_back(8'h3A);
        end
        if (tagEn && a) f.push_back(8'h2A);
        if (cr) f.push_back(8'h0D);
        f.push_back(8'h0A);
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkLog(input string name, input byteQ_t got, input byteQ_t exp);
        checkOutput({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) checkOutput($sformatf("%s[%0d]", name, i), {24'h0, got[i]}, {24'h0, exp[i]});
    endtask

    task automatic applyStimulus(input logic ts, input logic [23:0] cd, input logic al,
                                 input logic rdy, input logic r);
        @(negedge clk);
        time_1s = ts; clock_data = cd; alarm_en = al; tx_rdy = rdy; rst = r;
    endtask

    task automatic startFrame(input logic [23:0] cd, input logic al);
        curCd = cd; curAl = al;
        applyStimulus(1'b1, cd, al, 1'b1, 1'b0);
    endtask

    task automatic waitIdle(input int maxCyc, input bit randRdy, output int cyc);
        cyc = 0;
        while (cyc < maxCyc) begin
            applyStimulus(1'b0, curCd, curAl, randRdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            cyc++;
            if (!busy && !busy2) break;
        end
        checks++;
        if (busy || busy2) begin
            failures++;
            $display("[TB] FAIL wait_idle_timeout busy=%b busy2=%b expected idle", busy, busy2);
        end
    endtask

    // Model: busy while a frame queue is non-empty; the head is the presented byte.
    always @(posedge clk) begin
        if (tx_vld && tx_rdy) log0.push_back(tx_data);
        if (tx_vld2 && tx_rdy) log1.push_back(tx_data2);
        stallPrev = tx_vld && !tx_rdy && !rst;
        stallData = tx_data;
        if (rst) begin
            mq = {}; mBusy = 1'b0; mOver = 1'b0;
        end else begin
            mOver = 1'b0;
            if (mBusy) begin
                if (tx_rdy) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        if (time_1s) mq = buildFrame(clock_data, alarm_en, 1'b1, 1'b1);
                        else mBusy = 1'b0;
                    end else if (time_1s) mOver = 1'b1;
                end else if (time_1s) mOver = 1'b1;
            end else if (time_1s) begin
                mq = buildFrame(clock_data, alarm_en, 1'b1, 1'b1);
                mBusy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("model_tx_vld", tx_vld, mBusy);
            checkOutput("model_busy", busy, mBusy);
            checkOutput("model_overrun", overrun, mOver);
            if (mBusy && mq.size() > 0) checkOutput("model_tx_data", tx_data, mq[0]);
            if (stallPrev) begin
                checkOutput("stall_tx_vld", tx_vld, 1);
                checkOutput("stall_tx_data", tx_data, stallData);
            end
        end
    end

    initial begin
        byteQ_t expT1, exp, exp9;
        int     cyc;
        rst = 1'b1; time_1s = 1'b0; clock_data = 24'h0; alarm_en = 1'b0; tx_rdy = 1'b1;
        curCd = 24'h0; curAl = 1'b0;
        expT1 = '{8'h31, 8'h30, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h35, 8'h0D, 8'h0A};

        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        compareEn = 1'b1;
        checkOutput("reset_tx_vld", tx_vld, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_tx_data", tx_data, 8'h00);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);

        // T1: basic frame, latency and zero-bubble streaming
        log0 = {}; log1 = {};
        startFrame(24'h100205, 1'b0);
        applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
        checkOutput("T1_latency_vld", tx_vld, 1);
        checkOutput("T1_latency_busy", busy, 1);
        waitIdle(40, 1'b0, cyc);
        checkOutput("T1_frame_cycles", cyc, 10);
        checkLog("T1", log0, expT1);

        // T2: alarm tag, and the minimal-parameter instance
        log0 = {}; log1 = {};
        startFrame(24'h100200, 1'b1);
        waitIdle(40, 1'b0, cyc);
        exp  = '{8'h31, 8'h30, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h30, 8'h2A, 8'h0D, 8'h0A};
        exp9 = '{8'h31, 8'h30, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h30, 8'h0A};
        checkLog("T2_default", log0, exp);
        checkLog("T2_noTag_lf", log1, exp9);

        // T3: random backpressure
        log0 = {}; log1 = {};
        startFrame(24'h100205, 1'b0);
        waitIdle(300, 1'b1, cyc);
        checkLog("T3", log0, expT1);

        // T4: request mid-frame with changed inputs
        log0 = {}; log1 = {};
        startFrame(24'h100205, 1'b0);
        applyStimulus(1'b0, 24'h100205, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h235959, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 24'h235959, 1'b1, 1'b1, 1'b0);
        curCd = 24'h235959; curAl = 1'b1;
        applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
        checkOutput("T4_overrun", overrun, 1);
        checkOutput("T4_overrun2", overrun2, 1);
        applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
        checkOutput("T4_overrun_drop", overrun, 0);
        waitIdle(40, 1'b0, cyc);
        checkLog("T4", log0, expT1);

        // T4b: request aligned with the last-byte handshake
        log0 = {}; log1 = {};
        startFrame(24'h100205, 1'b0);
        cyc = 0;
        while (log0.size() < 9 && cyc < 30) begin
            applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
            cyc++;
        end
        checkOutput("T4b_reach_last", log0.size(), 9);
        time_1s = 1'b1; clock_data = 24'h000001; alarm_en = 1'b0;
        curCd = 24'h000001; curAl = 1'b0;
        applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
        checkOutput("T4b_overrun", overrun, 0);
        checkOutput("T4b_tx_vld", tx_vld, 1);
        checkOutput("T4b_first_byte", tx_data, 8'h30);
        waitIdle(40, 1'b0, cyc);
        exp = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h31, 8'h0D, 8'h0A};
        checkLog("T4b", log0, {expT1, exp});

        // Held request: one frame, further high cycles flagged as overrun
        log0 = {}; log1 = {};
        startFrame(24'h000002, 1'b0);
        applyStimulus(1'b1, curCd, curAl, 1'b1, 1'b0);
        applyStimulus(1'b1, curCd, curAl, 1'b1, 1'b0);
        waitIdle(40, 1'b0, cyc);
        exp = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h32, 8'h0D, 8'h0A};
        checkLog("held", log0, exp);

        // T5: out-of-range digits
        log0 = {}; log1 = {};
        startFrame(24'h2A5F00, 1'b0);
        waitIdle(40, 1'b0, cyc);
        exp  = '{8'h32, 8'h3F, 8'h3A, 8'h35, 8'h3F, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A};
        exp9 = '{8'h32, 8'h3F, 8'h3A, 8'h35, 8'h3F, 8'h3A, 8'h30, 8'h30, 8'h0A};
        checkLog("T5", log0, exp);
        checkLog("T5_noTag_lf", log1, exp9);

        // T6: reset in the middle of a frame
        log0 = {}; log1 = {};
        startFrame(24'h100205, 1'b0);
        cyc = 0;
        while (log0.size() < 4 && cyc < 30) begin
            applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
            cyc++;
        end
        checkOutput("T6_reach_byte4", log0.size(), 4);
        rst = 1'b1;
        applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
        checkOutput("T6_tx_vld", tx_vld, 0);
        checkOutput("T6_busy", busy, 0);
        checkOutput("T6_overrun", overrun, 0);
        log0 = {}; log1 = {};
        startFrame(24'h123456, 1'b1);
        waitIdle(40, 1'b0, cyc);
        exp = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h2A, 8'h0D, 8'h0A};
        checkLog("T6", log0, exp);

        applyStimulus(1'b0, curCd, curAl, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
